mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer that shares the processor's single memory port among NREQ requesters (requester 0 = instruction fetch, 1 = load/store unit in the default build). It grants one requester at a time, drives the memory request, waits for completion and returns the response to the granted requester. With `ARB_TIMEOUT_EN` defined, it also converts a hung memory access into an error response. It sits between the core pipeline and the memory wrapper in the synthesized core.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TMO, 64, timeout in cycles; used only with `ARB_TIMEOUT_EN`
- CLK  in  1  clock; all state changes on its rising edge
- RST  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  per-requester request
- req_we  in  NREQ  per-requester write enable
- req_addr  in  NREQ*AW  packed addresses; slice i belongs to requester i
- req_wdata  in  NREQ*DW  packed write data
- req_ready  out  NREQ  one-hot grant/accept strobe
- rsp_valid  out  NREQ  one-hot response strobe
- rsp_rdata  out  DW  response read data
- rsp_err  out  1  response error flag
- mem_valid  out  1  memory request valid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  memory accepted the request
- mem_rvalid  in  1  memory completion, for both reads and writes
- mem_rdata  in  DW  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any req_valid bit is set, pick g by round-robin: search ptr+1, ptr+2, … wrapping modulo NREQ.
  - req_ready[g] is combinational and high for exactly that cycle.
  - On the clock edge: latch g, req_we[g], req_addr[g], req_wdata[g]; set ptr := g; go to ISSUE.
- **ISSUE**
  - mem_valid=1, driven with the latched fields.
  - When mem_ready=1: go to WAIT.
  - mem_rvalid is ignored in this state.
- **WAIT**
  - mem_valid=0.
  - When mem_rvalid=1: on that edge, register rsp_valid[g]=1, rsp_rdata=mem_rdata (0 for writes), rsp_err=0; go to IDLE.
- **Response outputs**
  - rsp_valid is a registered one-cycle pulse.
  - rsp_rdata and rsp_err hold their last values when rsp_valid=0.
- **Requester rules**
  - Hold req_addr, req_we and req_wdata stable while req_valid is high and until req_ready.
  - Deasserting req_valid before the grant is legal; the request is withdrawn.
- **Memory rules**
  - mem_rvalid may arrive no earlier than the cycle after the mem_ready handshake.
  - mem_rvalid seen in IDLE or ISSUE is ignored.
- **Reset (also mid-transaction)**
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first).
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata.
  - Any outstanding memory response is dropped.
- **Simultaneous events**
  - Several req_valid bits: only the round-robin winner is granted.
  - rsp_valid pulse and the next grant in IDLE may occur in the same cycle.

## Timing
- Grant at cycle t (req_ready[g]=1).
- mem_valid rises at t+1.
- With mem_ready at t+1 and mem_rvalid at t+2: rsp_valid[g]=1 at t+3.
- The next grant can also occur at t+3.
- Minimum 3 cycles per transaction; one transaction outstanding at a time.
- Every extra cycle of mem_ready or mem_rvalid delay adds one cycle of latency.

## Configuration
- **`ARB_TIMEOUT_EN` defined**
  - A cycle counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When the counter reaches TMO-1 with no completion, on the next edge: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, mem_valid=0, state=IDLE.
  - A late mem_rvalid arriving afterwards is ignored.
  - If completion and timeout occur in the same cycle, completion wins and rsp_err=0.
- **`ARB_TIMEOUT_EN` undefined**
  - No counter is built; the FSM waits indefinitely.
  - rsp_err is constant 0.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10
  - default AW, DW, NREQ, TMO constants
  - requester index constants: REQ_IF=0, REQ_LSU=1
- One sub-module, rr_pick:
  - combinational round-robin picker
  - inputs: request vector and ptr
  - outputs: one-hot grant and binary index

## Test plan
- Reset, then req_valid=2'b01 for a read of addr 0x100; mem_ready and mem_rvalid with rdata 0xDEADBEEF each 1 cycle after the previous step -> req_ready=2'b01 at t, mem_valid at t+1, rsp_valid=2'b01 with rdata 0xDEADBEEF at t+3.
- Both requesters hold req_valid for 4 transactions -> grant order 0,1,0,1; no starvation.
- Write of 0x55 to 0x20 with mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable fields; rsp_valid after mem_rvalid; rsp_rdata=0.
- RST asserted while in WAIT, then a stale mem_rvalid -> outputs 0 immediately; no rsp_valid; next grant goes to requester 0.
- `ARB_TIMEOUT_EN`, TMO=8, memory never responds -> rsp_valid with rsp_err=1, rdata=0, 8 cycles after ISSUE entry; a later mem_rvalid is ignored.
- req_valid[1] pulsed for 1 cycle while the arbiter is busy -> never granted; no response.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// State encoding, default widths and requester indices.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10
   } arb_state_t;

   localparam int ARB_NREQ = 2;
   localparam int ARB_AW   = 32;
   localparam int ARB_DW   = 32;
   localparam int ARB_TMO  = 64;

   localparam int REQ_IF   = 0;
   localparam int REQ_LSU  = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ...
// modulo NREQ and returns the first requester found.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_idx
);

   logic          w_found;
   logic [IW-1:0] w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_j = IW'((int'(i_ptr) + k) % NREQ);
         if (!w_found && i_req[w_j]) begin
            w_found    = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the single memory port among NREQ requesters.
// Define ARB_TIMEOUT_EN to turn a hung access into an error response.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ = ARB_NREQ,
   parameter int AW   = ARB_AW,
   parameter int DW   = ARB_DW,
   parameter int TMO  = ARB_TMO
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int IW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TMO < 2) begin : g_bad_cfg
      $error("mem_port_arbiter: unsupported parameters");
   end

   arb_state_t      r_state;
   arb_state_t      w_next;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_gidx;
   logic [IW-1:0]   w_idx;
   logic [NREQ-1:0] w_gnt;
   logic [NREQ-1:0] r_rsp_valid;
   logic [DW-1:0]   r_rsp_rdata;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic            w_we;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_wdata;
   logic            w_take;
   logic            w_done;
   logic            w_tmo;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_take = (r_state == IDLE) && (|req_valid);
   assign w_done = (r_state == WAIT) && mem_rvalid;

   always_comb begin
      w_we    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_idx == IW'(i)) begin
            w_we    = req_we[i];
            w_addr  = req_addr[i*AW +: AW];
            w_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_take) w_next = ISSUE;
         ISSUE: begin
            if (w_tmo)          w_next = IDLE;
            else if (mem_ready) w_next = WAIT;
         end
         WAIT:    if (w_done || w_tmo) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ptr       <= IW'(NREQ - 1);
         r_gidx      <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= '0;
         if (w_take) begin
            r_gidx  <= w_idx;
            r_ptr   <= w_idx;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
         end
         if (w_done) begin
            r_rsp_valid <= NREQ'(1) << r_gidx;
            r_rsp_rdata <= r_we ? '0 : mem_rdata;
         end else if (w_tmo) begin
            r_rsp_valid <= NREQ'(1) << r_gidx;
            r_rsp_rdata <= '0;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO) + 1;

   logic [CW-1:0] r_cnt;
   logic          r_rsp_err;

   // Counter sits at zero in IDLE, so it starts from zero on ISSUE entry
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                  r_cnt <= '0;
      else if (r_state == IDLE) r_cnt <= '0;
      else                      r_cnt <= r_cnt + CW'(1);
   end

   assign w_tmo = (r_state != IDLE) && (r_cnt == CW'(TMO - 1)) && !w_done;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)         r_rsp_err <= 1'b0;
      else if (w_done) r_rsp_err <= 1'b0;
      else if (w_tmo)  r_rsp_err <= 1'b1;
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_tmo   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (!RST && r_state == IDLE) ? w_gnt : '0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign mem_valid = (r_state == ISSUE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; responses are checked
// against a queue of expected results filled as requests are driven.
module tb_mem_port_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TMO  = 8;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_we = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              mem_valid;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ready = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DW-1:0]     mem_rdata = '0;

   typedef struct packed {
      logic [NREQ-1:0] vld;
      logic [DW-1:0]   rdata;
      logic            err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW),
      .TMO  (TMO)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic rsp_monitor();
      forever begin
         @(negedge CLK);
         if (!RST && rsp_valid !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got valid=%b rdata=%h err=%b, required no response",
                        rsp_valid, rsp_rdata, rsp_err);
            end else begin
               mon_e = exp_q.pop_front();
               if (rsp_valid !== mon_e.vld || rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
                  errors++;
                  $display("FAIL rsp_data: got valid=%b rdata=%h err=%b, required valid=%b rdata=%h err=%b",
                           rsp_valid, rsp_rdata, rsp_err, mon_e.vld, mon_e.rdata, mon_e.err);
               end
            end
         end
      end
   endtask

   task automatic serve(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int rdy_dly, input int rv_dly, input logic [DW-1:0] rd);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (mem_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL serve_wait: mem_valid stayed %b, required 1 within 20 cycles", mem_valid);
         return;
      end
      for (int d = 0; d <= rdy_dly; d++) begin
         if (d > 0) cyc();
         checks++;
         if (mem_valid !== 1'b1 || mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) begin
            errors++;
            $display("FAIL mem_fields: got v=%b we=%b a=%h d=%h, required v=1 we=%b a=%h d=%h",
                     mem_valid, mem_we, mem_addr, mem_wdata, we, addr, wdata);
         end
         if (d == rdy_dly) mem_ready = 1'b1;
      end
      cyc();
      mem_ready = 1'b0;
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL mem_valid_wait: got %b, required 0", mem_valid);
      end
      repeat (rv_dly) cyc();
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      cyc();
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      req_valid = 2'b11;
      repeat (2) @(negedge CLK);
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_req_ready: got %b, required 00", req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rv=%b rd=%h re=%b mv=%b we=%b a=%h d=%h, required all 0",
                  rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata);
      end
      req_valid = '0;
      cyc();
      RST = 1'b0;
   endtask

   task automatic test_basic_read();
      cyc();
      req_valid = 2'b01;
      req_we    = 2'b00;
      req_addr  = {32'h0, 32'h100};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL read_grant: got %b, required 01", req_ready);
      end
      cyc();
      req_valid = 2'b00;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL read_issue: got v=%b a=%h we=%b, required v=1 a=00000100 we=0",
                  mem_valid, mem_addr, mem_we);
      end
      mem_ready = 1'b1;
      exp_q.push_back('{vld: 2'b01, rdata: 32'hDEADBEEF, err: 1'b0});
      cyc();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      checks++;
      if (mem_valid !== 1'b0 || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL read_wait: got mv=%b rv=%b, required mv=0 rv=00", mem_valid, rsp_valid);
      end
      cyc();
      mem_rvalid = 1'b0;
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 2'b01) begin
         errors++;
         $display("FAIL read_rsp_time: got %b at t+3, required 01", rsp_valid);
      end
      cyc();
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_hold: got rv=%b rd=%h, required rv=00 rd=deadbeef", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_write_stall();
      cyc();
      req_valid = 2'b10;
      req_we    = 2'b10;
      req_addr  = {32'h20, 32'h0};
      req_wdata = {32'h55, 32'h0};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL write_grant: got %b, required 10", req_ready);
      end
      exp_q.push_back('{vld: 2'b10, rdata: 32'h0, err: 1'b0});
      serve(1'b1, 32'h20, 32'h55, 3, 0, 32'hBAD0BAD0);
      req_valid = 2'b00;
      req_we    = 2'b00;
      cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL write_rsp: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] g;
      logic [DW-1:0]   rd;
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = {32'h2000, 32'h1000};
      req_wdata = {32'h22, 32'h11};
      for (int i = 0; i < 4; i++) begin
         g  = (i % 2 == 0) ? 2'b01 : 2'b10;
         rd = 32'hA0000000 + 32'(i);
         @(negedge CLK);
         checks++;
         if (req_ready !== g) begin
            errors++;
            $display("FAIL rr_grant%0d: got %b, required %b", i, req_ready, g);
         end
         exp_q.push_back('{vld: g, rdata: rd, err: 1'b0});
         if (g == 2'b01) serve(1'b0, 32'h1000, 32'h11, 0, i, rd);
         else            serve(1'b0, 32'h2000, 32'h22, 0, i, rd);
      end
      req_valid = 2'b00;
      cyc();
      checks++;
      if (mem_valid !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_done: got mv=%b pending=%0d, required mv=0 pending=0", mem_valid, exp_q.size());
      end
   endtask

   task automatic test_reset_in_wait();
      req_valid = 2'b10;
      req_we    = 2'b00;
      req_addr  = {32'h44, 32'h40};
      req_wdata = {32'h0, 32'h0};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL rst_wait_grant: got %b, required 10", req_ready);
      end
      cyc();
      req_valid = 2'b00;
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      RST = 1'b1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_we, mem_addr, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL rst_wait_outputs: got rr=%b rv=%b rd=%h re=%b mv=%b a=%h, required all 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_valid, mem_addr);
      end
      cyc();
      RST        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      cyc();
      mem_rvalid = 1'b0;
      cyc();
      req_valid = 2'b11;
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_wait_next: got %b, required 01", req_ready);
      end
      exp_q.push_back('{vld: 2'b01, rdata: 32'h0BADF00D, err: 1'b0});
      serve(1'b0, 32'h40, 32'h0, 0, 0, 32'h0BADF00D);
      req_valid = 2'b00;
      cyc();
   endtask

   task automatic test_withdraw();
      req_valid = 2'b01;
      req_addr  = {32'h88, 32'h80};
      req_wdata = {32'h0, 32'h0};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL wd_grant: got %b, required 01", req_ready);
      end
      cyc();
      req_valid = 2'b10;
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL wd_busy: got %b, required 00", req_ready);
      end
      cyc();
      req_valid = 2'b00;
      exp_q.push_back('{vld: 2'b01, rdata: 32'hC0FFEE00, err: 1'b0});
      serve(1'b0, 32'h80, 32'h0, 1, 0, 32'hC0FFEE00);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         checks++;
         if (req_ready !== 2'b00 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_idle%0d: got rr=%b mv=%b, required 00 and 0", i, req_ready, mem_valid);
         end
         cyc();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wd_rsp: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int k;
      bit seen;
      req_valid = 2'b01;
      req_addr  = {32'h0, 32'h300};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL tmo_grant: got %b, required 01", req_ready);
      end
      exp_q.push_back('{vld: 2'b01, rdata: 32'h0, err: 1'b1});
      cyc();
      req_valid = 2'b00;
      k    = 1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (rsp_valid !== '0) begin
            seen = 1'b1;
            break;
         end
         cyc();
         k++;
      end
      checks++;
      if (!seen || k != 9) begin
         errors++;
         $display("FAIL tmo_latency: got seen=%b at t+%0d, required seen=1 at t+9", seen, k);
      end
      cyc();
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL tmo_mem_valid: got %b, required 0", mem_valid);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h77;
      cyc();
      mem_rvalid = 1'b0;
      repeat (3) cyc();
      req_valid = 2'b10;
      req_addr  = {32'h310, 32'h0};
      @(negedge CLK);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL tmo_next_grant: got %b, required 10", req_ready);
      end
      exp_q.push_back('{vld: 2'b10, rdata: 32'h5151, err: 1'b0});
      serve(1'b0, 32'h310, 32'h0, 0, 0, 32'h5151);
      req_valid = 2'b00;
      cyc();
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         rsp_monitor();
      join_none
      test_reset();
      test_basic_read();
      test_write_stall();
      test_round_robin();
      test_reset_in_wait();
      test_withdraw();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      repeat (3) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
